product_collector: RTL
======================

# product_collector

Downstream buffer stage for the product factory. It captures every `product_valid` pulse together with its `product_output` byte and a product tag, then queues the entries in a show-ahead FIFO. A consumer drains the queue through a valid/ready handshake. The factory has no backpressure, so the collector absorbs bursts, counts dropped products when full, and holds a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `DATA_W`, 8: product data width; matches the factory output.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: connects to factory `product_valid`; a one-cycle pulse per product.
- `in_data`, input, DATA_W: connects to factory `product_output`.
- `in_tag`, input, 2: product type (`2'b01` = A, `2'b10` = B), aligned with `in_valid`.
- `flush`, input, 1: synchronous clear of the queue and statistics.
- `out_valid`, output, 1: the head entry is available.
- `out_ready`, input, 1: the consumer accepts the head entry.
- `out_data`, output, DATA_W+2: head entry, `{tag, data}`.
- `level`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky; set when a push is dropped.
- `drop_count`, output, 8: number of dropped pushes, saturating at 255.
- `checksum`, output, DATA_W: running checksum (see Configuration).

## Operation
- Push: `in_valid && !flush`. The entry is written if `level < DEPTH`, or if `level == DEPTH` and a pop occurs in the same cycle.
- Pop: `out_valid && out_ready`. The read pointer advances.
- Drop: a push with `level == DEPTH` and no pop in the same cycle.
  - The entry is discarded and `overflow` is set.
  - `drop_count` increments, holding at 8'hFF.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `level` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop occur together.
- Push with `level == 0`: no pop is possible that cycle, since `out_valid` is low. `level` becomes 1.
- `out_valid` equals `level != 0`.
- `out_data` shows the entry at the read pointer, driven combinationally from the registered storage and pointer.
- `out_data` is don't-care while `out_valid` is low; the bench must not check it.
- `flush` takes priority over push and pop in the same cycle. It zeroes the pointers, `level`, `overflow`, `drop_count` and `checksum`, and any push that cycle is lost without counting as a drop.
- `in_tag` values `2'b00` and `2'b11` are stored unchanged; the collector does not filter tags.

## Timing
- Reset values: `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0, `checksum`=0. `out_data` is don't-care.
- Reset asserted mid-operation clears every register immediately, whatever the handshake state.
- Push to `out_valid` latency is one cycle. An entry pushed at edge N is visible from edge N onward, so the consumer can pop it at edge N+1.
- Throughput is one push and one pop per cycle, sustained, with no bubbles.
- `overflow`, `drop_count` and `level` are registered and update at the same edge as the event that changes them.
- `out_valid` must stay high until the pop occurs. The entry does not change while `out_valid && !out_ready`.

## Configuration
- Macro: `PRODUCT_COLLECTOR_CHECKSUM_EN`.
- Defined: `checksum` is a register updated at every accepted push as `checksum <= checksum + in_data`, modulo 2^DATA_W. Dropped or flushed entries are not added.
- Undefined: `checksum` is tied to 0 and no checksum logic is built.
- The port exists in both builds.

## Test plan
- Single entry: push `in_data`=8'h0F with `in_tag`=01, `out_ready`=1 → `out_valid` rises after the push edge; `out_data`=10'h10F; popped next edge; `level` back to 0.
- Fill to full: DEPTH=8, `out_ready`=0, push values 1..10.
  - `level`=8.
  - `overflow`=1.
  - `drop_count`=2.
  - Pops then return 1..8 in order.
- Full with simultaneous push and pop: `level`=8, push 8'hAA together with a pop → no drop; `level` stays 8; 8'hAA is read last.
- Flush mid-stream: 3 entries queued plus a push in the flush cycle → `level`=0, `overflow`=0, `drop_count`=0, `out_valid`=0 on the next cycle.
- Pointer wrap: 20 push/pop pairs at full rate with `out_ready`=1 → data out matches data in, in order, and `level` never exceeds 1.
- Checksum build: push 8'h0F, 8'h0A, 8'hF0 → `checksum`=8'h09. Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/product_collector.sv
// -----------------------------------------------------------------------------
// product_collector
//
// Downstream buffer stage for the product factory. Each product_valid pulse is
// captured with its data byte and type tag into a show-ahead FIFO. A consumer
// drains the FIFO through a valid/ready handshake. The factory cannot be
// stalled, so the collector counts pushes it has to drop when full and keeps a
// sticky overflow flag.
//
// Optional feature macro: PRODUCT_COLLECTOR_CHECKSUM_EN
//   defined   -> checksum is a running modulo-2^DATA_W sum of accepted data
//   undefined -> checksum is tied to zero and no checksum logic is built
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : product pulse from the factory
//   in_data    : product data byte
//   in_tag     : product type tag, stored as-is
//   flush      : synchronous clear of queue and statistics (wins over push/pop)
//   out_valid  : head entry available
//   out_ready  : consumer accepts the head entry
//   out_data   : head entry {tag, data}
//   level      : occupancy 0..DEPTH
//   overflow   : sticky, set when a push is dropped
//   drop_count : dropped pushes, saturating at 255
//   checksum   : running checksum of accepted data (zero when feature off)
// -----------------------------------------------------------------------------
module product_collector #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_tag,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W+1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic [DATA_W-1:0]          checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_W+1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              overflow_r;
    logic [7:0]        drop_r;

    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              write_s;
    logic              drop_s;
    logic              valid_s;

    // Handshake decode: flush suppresses both push and pop; a full queue can
    // still accept a push when the head is popped in the same cycle.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        write_s = 1'b0;
        drop_s  = 1'b0;
        valid_s = (level_r != {LW{1'b0}});
        full_s  = (level_r == FULL_LEVEL);
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = in_valid;
            pop_s  = valid_s && out_ready;
        end
        write_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;
    end

    // Entry storage: written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(DATA_W + 2){1'b0}};
            end
        end else if (write_s) begin
            mem_r[wr_ptr_r] <= {in_tag, in_data};
        end
    end

    // Read/write pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({write_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Drop statistics: sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_r     <= 8'd0;
        end else if (flush) begin
            overflow_r <= 1'b0;
            drop_r     <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_r != 8'hFF) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

`ifdef PRODUCT_COLLECTOR_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Running checksum over accepted pushes only; drops and flushed pushes
    // never reach write_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (write_s) begin
            checksum_r <= checksum_r + in_data;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = {DATA_W{1'b0}};
`endif

    // Show-ahead head: driven straight from the storage and read pointer.
    assign out_data   = mem_r[rd_ptr_r];
    assign out_valid  = valid_s;
    assign level      = level_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_r;

endmodule
